// File: rtl/mem_wb_stage_buf.sv
// MEM/WB boundary stage: 2-entry skid buffer with valid/ready handshake,
// synchronous flush, load-data formatting at capture and a final writeback mux.
module mem_wb_stage_buf #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] data_in,
  input  logic [XLEN-1:0] alu_in,
  input  logic [RD_W-1:0] rd_in,
  input  logic            RegWrite_in,
  input  logic            MemtoReg_in,
  input  logic [2:0]      funct3_in,
  input  logic [1:0]      addr_lo_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] data_out,
  output logic [RD_W-1:0] rd_out,
  output logic            RegWrite_out,
  output logic            MemtoReg_out,
  output logic [XLEN-1:0] wb_data_out
);

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] data;
    logic [RD_W-1:0] rd;
    logic            regwrite;
    logic            memtoreg;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e  state_q, state_d;
  bundle_t h_q, h_d;
  bundle_t s_q, s_d;
  logic    in_ready_q, in_ready_d;
  bundle_t in_bundle;
  logic    acc;
  logic    pop;

  // Extract and extend the addressed byte/half/word from the raw read word.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] d,
                                               input logic [2:0]      f3,
                                               input logic [1:0]      off);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [31:0]     w;
    logic [XLEN-1:0] r;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[1], 4'b0000} +: 16];
    w = d[31:0];
    case (f3)
      3'b000:  r = XLEN'($signed(b));
      3'b100:  r = XLEN'(b);
      3'b001:  r = XLEN'($signed(h));
      3'b101:  r = XLEN'(h);
      3'b010:  r = XLEN'($signed(w));
      3'b110:  r = XLEN'(w);
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    in_bundle.alu      = alu_in;
    in_bundle.data     = fmt_load(data_in, funct3_in, addr_lo_in);
    in_bundle.rd       = rd_in;
    in_bundle.regwrite = RegWrite_in;
    in_bundle.memtoreg = MemtoReg_in;
  end

  assign acc = in_valid & in_ready_q;
  assign pop = out_valid & out_ready;

  // Next-state: flush wins over any simultaneous accept or pop.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            h_d     = in_bundle;
            state_d = ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            h_d = in_bundle;
          end else if (acc) begin
            s_d     = in_bundle;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            h_d     = s_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      h_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != EMPTY);
  assign alu_out      = h_q.alu;
  assign data_out     = h_q.data;
  assign rd_out       = h_q.rd;
  // x0 is never written; stale head contents are masked by out_valid.
  assign RegWrite_out = h_q.regwrite & out_valid & (h_q.rd != '0);
  assign MemtoReg_out = h_q.memtoreg & out_valid;
  assign wb_data_out  = MemtoReg_out ? h_q.data : h_q.alu;

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// Scoreboard bench for mem_wb_stage_buf: stimulus pushes expected bundles,
// a negedge monitor pops and compares every consumed head bundle.
module tb_mem_wb_stage_buf;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [31:0] alu_in;
  logic [4:0]  rd_in;
  logic        RegWrite_in;
  logic        MemtoReg_in;
  logic [2:0]  funct3_in;
  logic [1:0]  addr_lo_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic [31:0] data_out;
  logic [4:0]  rd_out;
  logic        RegWrite_out;
  logic        MemtoReg_out;
  logic [31:0] wb_data_out;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic [31:0] wb;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  mem_wb_stage_buf #(.XLEN(32), .RD_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .alu_in       (alu_in),
    .rd_in        (rd_in),
    .RegWrite_in  (RegWrite_in),
    .MemtoReg_in  (MemtoReg_in),
    .funct3_in    (funct3_in),
    .addr_lo_in   (addr_lo_in),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_out      (alu_out),
    .data_out     (data_out),
    .rd_out       (rd_out),
    .RegWrite_out (RegWrite_out),
    .MemtoReg_out (MemtoReg_out),
    .wb_data_out  (wb_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every consumed head bundle must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bundle actual_alu=%h expected=none at %0t", alu_out, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("alu_out", alu_out, e.alu);
        chk("data_out", data_out, e.data);
        chk("rd_out", 32'(rd_out), 32'(e.rd));
        chk("RegWrite_out", 32'(RegWrite_out), 32'(e.rw));
        chk("MemtoReg_out", 32'(MemtoReg_out), 32'(e.m2r));
        chk("wb_data_out", wb_data_out, e.wb);
      end
    end
  end

  // Present a bundle and hold it until accepted; exp_data is the hand-computed formatted load.
  task automatic drive(input logic [31:0] alu, input logic [31:0] data, input logic [4:0] rd,
                       input logic rw, input logic m2r, input logic [2:0] f3,
                       input logic [1:0] off, input logic [31:0] exp_data);
    exp_t e;
    bit   done;
    alu_in = alu; data_in = data; rd_in = rd; RegWrite_in = rw;
    MemtoReg_in = m2r; funct3_in = f3; addr_lo_in = off;
    in_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.alu = alu; e.data = exp_data; e.rd = rd;
        e.rw = rw && (rd != 5'd0); e.m2r = m2r;
        e.wb = m2r ? exp_data : alu;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_accepted expected=accepted alu=%h", alu);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    data_in = '0; alu_in = '0; rd_in = '0; RegWrite_in = 1'b0;
    MemtoReg_in = 1'b0; funct3_in = 3'b011; addr_lo_in = 2'b00;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wb_data_out", wb_data_out, 32'd0);
    chk("rst_RegWrite_out", 32'(RegWrite_out), 32'd0);
    #11 reset = 1'b0;
    @(posedge clk); #1;

    // Streaming at full throughput
    out_ready = 1'b1;
    drive(32'h10, 32'hAAAA0001, 5'd1, 1'b1, 1'b0, 3'b011, 2'b00, 32'hAAAA0001);
    chk("stream_latency_valid", 32'(out_valid), 32'd1);
    drive(32'h20, 32'hAAAA0002, 5'd2, 1'b1, 1'b0, 3'b011, 2'b00, 32'hAAAA0002);
    chk("stream_in_ready", 32'(in_ready), 32'd1);
    drive(32'h30, 32'hAAAA0003, 5'd3, 1'b1, 1'b0, 3'b011, 2'b00, 32'hAAAA0003);
    chk("stream_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Backpressure: A then B fill the buffer, C is held off
    out_ready = 1'b0;
    drive(32'hA0, 32'h0, 5'd5, 1'b1, 1'b0, 3'b011, 2'b00, 32'h0);
    drive(32'hB0, 32'h0, 5'd6, 1'b1, 1'b0, 3'b011, 2'b00, 32'h0);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    alu_in = 32'hC0; data_in = 32'h0; rd_in = 5'd8; RegWrite_in = 1'b1;
    MemtoReg_in = 1'b0; funct3_in = 3'b011; addr_lo_in = 2'b00; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_head", alu_out, 32'hA0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
    drive(32'hC0, 32'h0, 5'd8, 1'b1, 1'b0, 3'b011, 2'b00, 32'h0);
    drain();

    // Load formatting on 0x80FF7F01
    drive(32'h1003, 32'h80FF7F01, 5'd9, 1'b1, 1'b1, 3'b000, 2'd3, 32'hFFFFFF80);
    drive(32'h1003, 32'h80FF7F01, 5'd9, 1'b1, 1'b1, 3'b100, 2'd3, 32'h00000080);
    drive(32'h1002, 32'h80FF7F01, 5'd9, 1'b1, 1'b1, 3'b001, 2'd2, 32'hFFFF80FF);
    drive(32'h1000, 32'h80FF7F01, 5'd9, 1'b1, 1'b1, 3'b101, 2'd0, 32'h00007F01);
    drive(32'h1000, 32'h80FF7F01, 5'd9, 1'b1, 1'b1, 3'b010, 2'd0, 32'h80FF7F01);
    drive(32'h1001, 32'h80FF7F01, 5'd9, 1'b1, 1'b1, 3'b000, 2'd1, 32'h0000007F);
    drive(32'h1003, 32'h80FF7F01, 5'd9, 1'b1, 1'b1, 3'b001, 2'd3, 32'hFFFF80FF);
    drive(32'h1001, 32'h80FF7F01, 5'd9, 1'b1, 1'b1, 3'b101, 2'd1, 32'h00007F01);
    drain();

    // x0 suppression and writeback select
    drive(32'h1234, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 3'b010, 2'd0, 32'hDEADBEEF);
    drive(32'h1234, 32'hDEADBEEF, 5'd7, 1'b1, 1'b0, 3'b010, 2'd0, 32'hDEADBEEF);
    drain();

    // Flush while FULL with an incoming bundle
    out_ready = 1'b0;
    drive(32'hF1, 32'h0, 5'd10, 1'b1, 1'b0, 3'b011, 2'b00, 32'h0);
    drive(32'hF2, 32'h0, 5'd11, 1'b1, 1'b0, 3'b011, 2'b00, 32'h0);
    flush = 1'b1; in_valid = 1'b1; alu_in = 32'hDEAD; rd_in = 5'd12;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush_full_out_valid", 32'(out_valid), 32'd0);
    chk("flush_full_in_ready", 32'(in_ready), 32'd1);

    // Flush in ONE where the incoming bundle would otherwise be accepted
    drive(32'hF3, 32'h0, 5'd13, 1'b1, 1'b0, 3'b011, 2'b00, 32'h0);
    flush = 1'b1; in_valid = 1'b1; alu_in = 32'hBEEF; rd_in = 5'd14;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush_one_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_no_ghost", 32'(out_valid), 32'd0);

    // Reset mid-stream with the buffer FULL
    out_ready = 1'b0;
    drive(32'h51, 32'h0, 5'd15, 1'b1, 1'b0, 3'b011, 2'b00, 32'h0);
    drive(32'h52, 32'h0, 5'd16, 1'b1, 1'b0, 3'b011, 2'b00, 32'h0);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_RegWrite_out", 32'(RegWrite_out), 32'd0);
    chk("midrst_wb_data_out", wb_data_out, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(32'h77, 32'h0, 5'd17, 1'b1, 1'b0, 3'b011, 2'b00, 32'h0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage_buf.md
Name: mem_wb_stage_buf

Overview:
Parametrised MEM/WB boundary stage that replaces the plain always-enabled MEM/WB register.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the writeback side can stall without a combinational ready path back into MEM.
- Adds a synchronous flush.
- Formats load data (byte/half/word, signed/unsigned) at capture.
- Presents the final writeback value so the register file sees one ready-to-write operand.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
RD_W, 5, destination register index width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
in_valid  input  1  MEM stage presents a bundle
in_ready  output  1  stage can accept a bundle; registered
data_in  input  XLEN  raw memory read word
alu_in  input  XLEN  ALU result / effective address
rd_in  input  RD_W  destination register
RegWrite_in  input  1  register write enable
MemtoReg_in  input  1  1 selects load data for writeback
funct3_in  input  3  load size/sign code
addr_lo_in  input  2  byte offset alu_in[1:0]
flush  input  1  synchronous discard of all held bundles
out_valid  output  1  head bundle valid
out_ready  input  1  WB consumes head bundle
alu_out  output  XLEN  head ALU result
data_out  output  XLEN  head formatted load data
rd_out  output  RD_W  head destination
RegWrite_out  output  1  head RegWrite AND out_valid AND (rd_out != 0)
MemtoReg_out  output  1  head MemtoReg
wb_data_out  output  XLEN  MemtoReg_out ? data_out : alu_out (combinational from registers)

Behaviour:
- Storage: a head register (H) and a skid register (S), each with a valid bit.
  - out_valid = H.valid.
  - in_ready = !S.valid, registered.
- States:
  - EMPTY: H and S both invalid.
  - ONE: H valid, S invalid.
  - FULL: H and S both valid.
- Definitions: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions:
  - EMPTY: on acc, the bundle goes to H -> ONE.
  - ONE:
    - acc and pop: the bundle replaces H; stays ONE.
    - acc only: the bundle goes to S -> FULL; in_ready=0 next cycle.
    - pop only -> EMPTY.
  - FULL: in_ready=0, so no acc.
    - pop: S moves to H -> ONE; in_ready=1 next cycle.
- Ordering: strict FIFO; no bundle is dropped or duplicated outside flush.
- Latency:
  - 1 cycle from acc to out_valid when EMPTY.
  - Throughput is 1 bundle/cycle while out_ready=1.
- Flush:
  - At the next edge both valid bits clear and in_ready=1.
  - Flush has priority over a simultaneous acc and pop; the incoming bundle is discarded.
- Reset (asynchronous): state EMPTY, in_ready=1. All data outputs are 0 and all control outputs are 0, including wb_data_out.
  - Reset may assert mid-transfer; held bundles are lost.
  - The first edge after deassertion behaves as EMPTY.
- Load formatting, applied to data_in at capture and stored already formatted:
  - 000 lb: byte data_in[8*addr_lo+7 : 8*addr_lo], sign-extended to XLEN.
  - 100 lbu: same byte, zero-extended.
  - 001 lh: halfword data_in[16*addr_lo[1]+15 : 16*addr_lo[1]], sign-extended; addr_lo[0] is ignored.
  - 101 lhu: same halfword, zero-extended.
  - 010 lw: data_in[31:0], sign-extended to XLEN.
  - 110 lwu (XLEN=64 only): data_in[31:0], zero-extended.
  - 011 ld, and any other code: data_in passed unchanged.
- Formatting runs regardless of MemtoReg_in.
- Invalid entries hold stale data; every control output is qualified by out_valid.
- rd_out == 0 forces RegWrite_out=0; x0 is never written.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert reset with H and S holding bundles.
  - Response: immediately out_valid=0, RegWrite_out=0, wb_data_out=0, in_ready=1.
- Streaming:
  - Stimulus: out_ready=1; accept alu_in=0x10, 0x20, 0x30 on consecutive cycles.
  - Response: out_valid from cycle+1; alu_out shows 0x10, 0x20, 0x30 on consecutive cycles; in_ready stays 1.
- Backpressure:
  - Stimulus: out_ready=0; send A(rd=5), then B(rd=6).
  - Response: state FULL and in_ready=0; C is held off. Raising out_ready pops A then B in order, and in_ready returns to 1 one cycle after the first pop.
- Load formatting:
  - Stimulus: data_in=0x80FF7F01 with MemtoReg=1.
  - Response:
    - lb, off 3 -> 0xFFFFFF80
    - lbu, off 3 -> 0x00000080
    - lh, off 2 -> 0xFFFF80FF
    - lhu, off 0 -> 0x00007F01
    - lw -> 0x80FF7F01
  - wb_data_out equals data_out in each case.
- Flush:
  - Stimulus: flush with FULL plus a simultaneous in_valid.
  - Response: next cycle out_valid=0 and in_ready=1; the incoming bundle never appears.
- x0 suppression and select:
  - Stimulus: bundle with rd_in=0, RegWrite_in=1, MemtoReg_in=0, alu_in=0x1234.
  - Response: RegWrite_out=0, wb_data_out=0x1234.
  - Same bundle with rd_in=7: RegWrite_out=1.
